inst_mem_loader: RTL and testbench

Boot loader that sits directly upstream of the 8192×32 instruction memory. It accepts a framed byte stream over a valid/ready interface and packs it into 32-bit little-endian words. It writes those words into the memory through its Avalon-MM write port while holding the processor in reset. It releases the processor once a complete image has been written and, optionally, checksum-verified.

---
 rtl/inst_loader_pkg.sv | 27 ++
 rtl/loader_word_packer.sv | 36 +++
 rtl/inst_mem_loader.sv | 183 ++++++++++++++++++
 tb/tb_inst_mem_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
`default_nettype none

package inst_loader_pkg;

  localparam int HDR_W  = 16;
  localparam int WORD_W = 32;
  localparam logic [3:0] BYTEEN_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR0  = 3'd1,
    ST_HDR1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_WRITE = 3'd4,
    ST_CSUM  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  // States in which the loader takes a byte from the stream.
  function automatic logic accepts_bytes(input state_t s);
    return (s == ST_HDR0) || (s == ST_HDR1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/loader_word_packer.sv
// Little-endian 4-byte packer: first byte lands in bits 7:0, word_full flags the 4th byte.
`default_nettype none

module loader_word_packer
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word,
  output logic              word_full
);

  logic [1:0] byte_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (clear) begin
      word     <= '0;
      byte_idx <= '0;
    end else if (byte_valid) begin
      // Shift right so the earliest byte ends up least significant.
      word     <= {byte_in, word[WORD_W-1:8]};
      byte_idx <= byte_idx + 2'd1;
    end
  end

  assign word_full = byte_valid && (byte_idx == 2'd3);

endmodule

`default_nettype wire

// File: rtl/inst_mem_loader.sv
// Boot loader: framed byte stream -> 32-bit writes into instruction memory, CPU held meanwhile.
// Optional trailing checksum byte enabled by defining INST_LOADER_CHECKSUM_EN.
`default_nettype none

module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int DEPTH     = 8192,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [WORD_W-1:0] mem_writedata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam logic [31:0]       MAX_WORDS = 32'(DEPTH - BASE_ADDR);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  state_t state, state_next;

  logic [7:0]        n_lo;
  logic [HDR_W-1:0] n_words;
  logic [HDR_W-1:0] word_idx;
  logic [HDR_W-1:0] word_idx_inc;
  logic [HDR_W-1:0] n_full;
  logic              n_over;
  logic              accept;
  logic              writing;

  logic              load_start;
  logic              set_done;
  logic              set_error;
  logic              pack_valid;
  logic [WORD_W-1:0] packed_word;
  logic              word_full;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic [7:0] sum_final;
  assign sum_final = sum + in_data;
`endif

  assign in_ready     = accepts_bytes(state);
  assign accept       = in_valid & in_ready;
  assign n_full       = {in_data, n_lo};
  assign n_over       = ({16'd0, n_full} > MAX_WORDS);
  assign word_idx_inc = word_idx + 16'd1;
  assign pack_valid   = accept && (state == ST_DATA);

  loader_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (load_start),
    .byte_valid (pack_valid),
    .byte_in    (in_data),
    .word       (packed_word),
    .word_full  (word_full)
  );

  always_comb begin
    state_next = state;
    load_start = 1'b0;
    set_done   = 1'b0;
    set_error  = 1'b0;
    case (state)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_next = ST_HDR0;
          load_start = 1'b1;
        end
      end
      ST_HDR0: begin
        if (accept) state_next = ST_HDR1;
      end
      ST_HDR1: begin
        if (accept) begin
          if (n_over) begin
            state_next = ST_ERR;
            set_error  = 1'b1;
          end else if (n_full == '0) begin
`ifdef INST_LOADER_CHECKSUM_EN
            state_next = ST_CSUM;
`else
            state_next = ST_IDLE;
            set_done   = 1'b1;
`endif
          end else begin
            state_next = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (word_full) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        if (word_idx_inc == n_words) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_next = ST_CSUM;
`else
          state_next = ST_IDLE;
          set_done   = 1'b1;
`endif
        end else begin
          state_next = ST_DATA;
        end
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) begin
          if (sum_final == 8'd0) begin
            state_next = ST_IDLE;
            set_done   = 1'b1;
          end else begin
            state_next = ST_ERR;
            set_error  = 1'b1;
          end
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      n_lo     <= '0;
      n_words  <= '0;
      word_idx <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state <= state_next;
      if (load_start) begin
        done     <= 1'b0;
        error    <= 1'b0;
        word_idx <= '0;
      end
      if (accept && (state == ST_HDR0)) n_lo <= in_data;
      if (accept && (state == ST_HDR1)) n_words <= n_full;
      if (state == ST_WRITE) word_idx <= word_idx_inc;
      if (set_done)  done  <= 1'b1;
      if (set_error) error <= 1'b1;
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  // Header bytes are deliberately excluded from the running sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (load_start) begin
      sum <= '0;
    end else if (pack_valid) begin
      sum <= sum + in_data;
    end
  end
`endif

  // Memory port is decoded from state so reset silences it immediately.
  assign writing        = (state == ST_WRITE);
  assign mem_write      = writing;
  assign mem_chipselect = writing;
  assign mem_byteenable = writing ? BYTEEN_ALL : 4'h0;
  assign mem_address    = writing ? (BASE + word_idx[ADDR_W-1:0]) : '0;
  assign mem_writedata  = writing ? packed_word : '0;
  assign cpu_hold       = (state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader (base 0 and base 8190 instances).
`default_nettype none

module tb_inst_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start0, start1, in_valid;
  logic [7:0]  in_data;

  logic        in_ready0, mem_chipselect0, mem_write0, cpu_hold0, done0, error0;
  logic [12:0] mem_address0;
  logic [3:0]  mem_byteenable0;
  logic [31:0] mem_writedata0;

  logic        in_ready1, mem_chipselect1, mem_write1, cpu_hold1, done1, error1;
  logic [12:0] mem_address1;
  logic [3:0]  mem_byteenable1;
  logic [31:0] mem_writedata1;

  inst_mem_loader #(.ADDR_W(13), .DEPTH(8192), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .mem_address(mem_address0), .mem_byteenable(mem_byteenable0),
    .mem_chipselect(mem_chipselect0), .mem_write(mem_write0), .mem_writedata(mem_writedata0),
    .cpu_hold(cpu_hold0), .done(done0), .error(error0)
  );

  inst_mem_loader #(.ADDR_W(13), .DEPTH(8192), .BASE_ADDR(8190)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .mem_address(mem_address1), .mem_byteenable(mem_byteenable1),
    .mem_chipselect(mem_chipselect1), .mem_write(mem_write1), .mem_writedata(mem_writedata1),
    .cpu_hold(cpu_hold1), .done(done1), .error(error1)
  );

  int checks = 0;
  int errors = 0;
  int timeouts = 0;
  int bad_strobe = 0;

  logic [12:0] wa0[$], wa1[$];
  logic [31:0] wd0[$], wd1[$];
  logic [7:0]  pay[$];

  // Write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_write0) begin
      wa0.push_back(mem_address0);
      wd0.push_back(mem_writedata0);
      if (!mem_chipselect0 || mem_byteenable0 !== 4'hF) bad_strobe++;
    end
    if (mem_write1) begin
      wa1.push_back(mem_address1);
      wd1.push_back(mem_writedata1);
      if (!mem_chipselect1 || mem_byteenable1 !== 4'hF) bad_strobe++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] good_csum();
    logic [7:0] s = 8'h00;
    foreach (pay[i]) s = s + pay[i];
    return 8'h00 - s;
  endfunction

  task automatic do_start(input int sel);
    if (sel == 1) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input bit gaps);
    int t = 0;
    int g = 0;
    if (gaps) begin
      while (($urandom_range(1, 0) == 0) && g < 8) begin
        @(negedge clk);
        g++;
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!((sel == 1) ? in_ready1 : in_ready0) && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) timeouts++;
    else @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_hdr(input int sel, input logic [15:0] n, input bit gaps);
    send_byte(sel, n[7:0], gaps);
    send_byte(sel, n[15:8], gaps);
  endtask

  task automatic send_payload(input int sel, input int count, input bit gaps);
    for (int i = 0; i < count; i++) send_byte(sel, pay[i], gaps);
  endtask

  task automatic wait_idle(input int sel, input string tag);
    int t = 0;
    while (((sel == 1) ? cpu_hold1 : cpu_hold0) && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, " completes"}, 32'(t < 40), 32'd1);
  endtask

  task automatic check_writes(input int sel, input string tag, input int b, input int base, input int nw);
    int got;
    logic [31:0] exp_d;
    got = ((sel == 1) ? wa1.size() : wa0.size()) - b;
    check({tag, " write count"}, 32'(got), 32'(nw));
    for (int k = 0; k < nw && k < got; k++) begin
      exp_d = {pay[4*k+3], pay[4*k+2], pay[4*k+1], pay[4*k]};
      check({tag, " addr"}, 32'((sel == 1) ? wa1[b+k] : wa0[b+k]), 32'(base + k));
      check({tag, " data"}, (sel == 1) ? wd1[b+k] : wd0[b+k], exp_d);
    end
  endtask

  initial begin
    int b;
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    repeat (2) @(negedge clk);

    check("reset in_ready", 32'(in_ready0), 32'd0);
    check("reset mem_write", 32'(mem_write0), 32'd0);
    check("reset chipselect", 32'(mem_chipselect0), 32'd0);
    check("reset cpu_hold", 32'(cpu_hold0), 32'd0);
    check("reset done/error", 32'({done0, error0}), 32'd0);
    check("reset byteenable", 32'(mem_byteenable0), 32'd0);
    check("reset writedata", mem_writedata0, 32'd0);
    check("reset address base8190", 32'(mem_address1), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Back-to-back load of two words.
    b = wa0.size();
    do_start(0);
    check("hold after start", 32'(cpu_hold0), 32'd1);
    send_hdr(0, 16'd2, 1'b0);
    send_payload(0, 8, 1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(0, good_csum(), 1'b0);
`endif
    wait_idle(0, "load1");
    check("load1 count", 32'(wa0.size() - b), 32'd2);
    check("load1 word0", wd0[b], 32'h44332211);
    check("load1 addr1", 32'(wa0[b+1]), 32'd1);
    check("load1 word1", wd0[b+1], 32'hDDCCBBAA);
    check("load1 done/error/hold", 32'({done0, error0, cpu_hold0}), 32'b100);

`ifdef INST_LOADER_CHECKSUM_EN
    // Wrong checksum: data still written, error latched, CPU stays held.
    b = wa0.size();
    do_start(0);
    send_hdr(0, 16'd2, 1'b0);
    send_payload(0, 8, 1'b0);
    send_byte(0, good_csum() + 8'd1, 1'b0);
    repeat (3) @(negedge clk);
    check_writes(0, "badcsum", b, 0, 2);
    check("badcsum done/error/hold", 32'({done0, error0, cpu_hold0}), 32'b011);
    do_start(0);
    check("badcsum restart clears error", 32'(error0), 32'd0);
`else
    do_start(0);
`endif

    // Empty image.
    b = wa0.size();
    send_hdr(0, 16'd0, 1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(0, 8'h00, 1'b0);
`endif
    wait_idle(0, "empty");
    check("empty writes", 32'(wa0.size() - b), 32'd0);
    check("empty done/error", 32'({done0, error0}), 32'b10);

    // Oversized header: N = 8193.
    b = wa0.size();
    do_start(0);
    send_hdr(0, 16'd8193, 1'b0);
    repeat (2) @(negedge clk);
    check("oversize error/hold/done", 32'({error0, cpu_hold0, done0}), 32'b110);
    check("oversize in_ready", 32'(in_ready0), 32'd0);
    check("oversize writes", 32'(wa0.size() - b), 32'd0);

    // Irregular in_valid, restarting from the error state.
    b = wa0.size();
    do_start(0);
    check("restart from err clears error", 32'(error0), 32'd0);
    send_hdr(0, 16'd2, 1'b1);
    send_payload(0, 8, 1'b1);
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(0, good_csum(), 1'b1);
`endif
    wait_idle(0, "gaps");
    check_writes(0, "gaps", b, 0, 2);
    check("gaps done", 32'(done0), 32'd1);

    // Asynchronous reset in the middle of the payload.
    b = wa0.size();
    do_start(0);
    send_hdr(0, 16'd2, 1'b0);
    send_payload(0, 5, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midreset hold/ready/write", 32'({cpu_hold0, in_ready0, mem_write0}), 32'd0);
    check("midreset done/error", 32'({done0, error0}), 32'd0);
    check("midreset partial writes", 32'(wa0.size() - b), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    b = wa0.size();
    do_start(0);
    send_hdr(0, 16'd2, 1'b0);
    send_payload(0, 8, 1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(0, good_csum(), 1'b0);
`endif
    wait_idle(0, "after reset");
    check_writes(0, "after reset", b, 0, 2);
    check("after reset done", 32'(done0), 32'd1);

    // Top-of-memory base: N=2 fits, N=3 does not.
    b = wa1.size();
    do_start(1);
    send_hdr(1, 16'd2, 1'b0);
    send_payload(1, 8, 1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(1, good_csum(), 1'b0);
`endif
    wait_idle(1, "base8190");
    check_writes(1, "base8190", b, 8190, 2);
    check("base8190 done/error", 32'({done1, error1}), 32'b10);
    b = wa1.size();
    do_start(1);
    send_hdr(1, 16'd3, 1'b0);
    repeat (2) @(negedge clk);
    check("base8190 n3 error/hold", 32'({error1, cpu_hold1}), 32'b11);
    check("base8190 n3 writes", 32'(wa1.size() - b), 32'd0);

    check("strobe qualifiers", 32'(bad_strobe), 32'd0);
    check("handshake timeouts", 32'(timeouts), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
